mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit, a sibling of the single-cycle combinational ALU in the execute stage.
- Takes operand pairs through a valid/ready request handshake and returns one XLEN-bit result through a valid/ready response handshake.
- Multi-cycle: the core stalls on in_ready / out_valid.
- Covers all eight M-extension ops, including divide-by-zero and signed-overflow semantics.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request (high only in IDLE).
- in_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_a  in  XLEN  rs1 operand.
- in_b  in  XLEN  rs2 operand.
- kill  in  1  pipeline flush; aborts any operation in progress.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  result.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_result=0, iteration counter 0.
- States:
  - IDLE: in_ready=1. An accept (in_valid && in_ready && !kill) latches op, operands and sign flags, then goes to CALC, or to DONE for special cases.
  - CALC: one iteration per cycle, counter 0..XLEN-1. After iteration XLEN-1, sign fix-up is applied and the state goes to DONE.
  - DONE: out_valid=1 and out_result holds stable until out_valid && out_ready, then back to IDLE. There is no accept in the same cycle as the result handshake; back-to-back issue costs one IDLE cycle.
- Latency: if a request is accepted in cycle N, out_valid is high from cycle N+XLEN+1 (N+33 for XLEN=32).
- Special cases reach DONE in cycle N+1 with no iteration:
  - divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = in_a.
  - signed overflow, DIV/REM with in_a = 0x80000000 and in_b = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Multiply:
  - Unsigned shift-add of operand magnitudes into a 2*XLEN accumulator.
  - Signedness: MULH both operands signed; MULHSU in_a signed, in_b unsigned; MULHU and MUL unsigned magnitudes (the MUL low half is sign-agnostic).
  - The product is negated when exactly one signed operand is negative.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes (signed ops use absolute values; DIVU/REMU use raw operands).
  - Quotient is negated if operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
  - The most negative dividend is handled without overflow because magnitudes are unsigned XLEN-bit.
- Kill:
  - In any state, kill forces IDLE on the next edge with out_valid=0.
  - If kill and in_valid are high in the same IDLE cycle, kill wins and the request is not accepted.
  - kill in DONE discards the result even when out_ready is high that cycle.
- Reset mid-operation has the same effect as kill, and all outputs return to their reset values.
- in_a, in_b and in_op are don't-care outside the accept cycle.

Optional Feature:
- MDU_FAST_MUL_EN.
- Defined: the four multiply ops use a single combinational 2*XLEN signed/unsigned product computed at accept and go to DONE in cycle N+1. Divide ops are unchanged.
- Undefined: multiplies use the iterative CALC path with latency XLEN+1. There is no multiplier array.

Decomposition:
- Shared core-definitions package:
  - mdu_op_t enum: the eight funct3 encodings above.
  - mdu_state_t: IDLE, CALC, DONE.
  - constants MDU_DIV_BIT (op[2]) and MDU_XLEN.
- Natural sub-module: mdu_fixup, a purely combinational block that does operand magnitude extraction before iteration and result negation/selection after it. It is instanced once at the input and once at the output.
- The FSM and iteration datapath stay in mdu_iter.

Test Plan:
- MULHU 0xFFFFFFFF x 0xFFFFFFFF, out_ready=1 -> 0xFFFFFFFE, out_valid in cycle N+33 (N+1 with MDU_FAST_MUL_EN); MUL same operands -> 0x00000001.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. All four return in cycle N+1.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_result stable, in_ready=0; result pops on the first cycle with out_ready=1; in_ready=1 on the next cycle.
- kill in CALC cycle 5 -> IDLE next cycle with no out_valid, then a new DIVU 9/3 -> 3. Also: rst in CALC -> reset values; kill together with in_valid in IDLE -> no accept.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package mdu_iter_pkg;

    localparam int unsigned MDU_XLEN    = 32;
    localparam int unsigned MDU_DIV_BIT = 2;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    function automatic logic op_signed_a(input mdu_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_signed_b(input mdu_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mdu_fixup.sv
// Conditional two's-complement of a {hi, lo} pair: either the full 2*XLEN
// value or each half independently. Used for operand magnitudes and result signs.
module mdu_fixup
    import mdu_iter_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN
) (
    input  logic [2*XLEN-1:0] i_val,
    input  logic              i_neg_wide,
    input  logic              i_neg_hi,
    input  logic              i_neg_lo,
    output logic [2*XLEN-1:0] o_val
);

    logic [XLEN-1:0] w_hi;
    logic [XLEN-1:0] w_lo;

    assign w_hi = i_val[2*XLEN-1:XLEN];
    assign w_lo = i_val[XLEN-1:0];

    always_comb begin
        o_val = i_val;
        if (i_neg_wide) begin
            o_val = -i_val;
        end else begin
            o_val = {(i_neg_hi ? -w_hi : w_hi), (i_neg_lo ? -w_lo : w_lo)};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit with valid/ready request and response.
// Define MDU_FAST_MUL_EN for single-cycle multiplies through a combinational product.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    localparam int unsigned W2    = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t       r_state, w_state_nxt;
    mdu_op_t          r_op, w_op;
    logic [CNT_W-1:0] r_cnt;
    logic [W2-1:0]    r_acc, w_acc_nxt, w_mag, w_fix_val;
    logic [XLEN-1:0]  r_opb, r_result, w_short_res, w_fix_res;
    logic             r_neg_a, r_neg_b, r_in_ready, r_out_valid;
    logic             w_accept, w_last, w_is_div, w_neg_a, w_neg_b;
    logic             w_div0, w_ovf, w_short, w_fix_wide, w_fix_hi, w_fix_lo;
    logic [XLEN:0]    w_sum, w_mul_hi, w_rs, w_diff;

    assign w_op     = mdu_op_t'(in_op);
    assign w_is_div = in_op[MDU_DIV_BIT];
    assign w_neg_a  = op_signed_a(w_op) & in_a[XLEN-1];
    assign w_neg_b  = op_signed_b(w_op) & in_b[XLEN-1];
    assign w_div0   = w_is_div && (in_b == '0);
    assign w_ovf    = ((w_op == OP_DIV) || (w_op == OP_REM)) && (in_a == INT_MIN) && (in_b == '1);

    mdu_fixup #(.XLEN(XLEN)) u_fix_in (
        .i_val      ({in_a, in_b}),
        .i_neg_wide (1'b0),
        .i_neg_hi   (w_neg_a),
        .i_neg_lo   (w_neg_b),
        .o_val      (w_mag)
    );

`ifdef MDU_FAST_MUL_EN
    logic [W2-1:0] w_prod;
    assign w_prod = {{XLEN{w_neg_a}}, in_a} * {{XLEN{w_neg_b}}, in_b};
`endif

    // Requests that complete without iterating
    always_comb begin
        w_short     = w_div0 || w_ovf;
        w_short_res = '0;
        if (w_div0) begin
            w_short_res = in_op[1] ? in_a : '1;
        end else if (w_ovf) begin
            w_short_res = in_op[1] ? '0 : INT_MIN;
        end
`ifdef MDU_FAST_MUL_EN
        if (!w_is_div) begin
            w_short     = 1'b1;
            w_short_res = (w_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[W2-1:XLEN];
        end
`endif
    end

    // One shift-add (multiply) or restoring-subtract (divide) step
    always_comb begin
        w_sum    = {1'b0, r_acc[W2-1:XLEN]} + {1'b0, r_opb};
        w_mul_hi = r_acc[0] ? w_sum : {1'b0, r_acc[W2-1:XLEN]};
        w_rs     = {r_acc[W2-1:XLEN], r_acc[XLEN-1]};
        w_diff   = w_rs - {1'b0, r_opb};
        if (!r_op[MDU_DIV_BIT]) begin
            w_acc_nxt = {w_mul_hi, r_acc[XLEN-1:1]};
        end else if (w_diff[XLEN]) begin
            w_acc_nxt = {w_rs[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        end else begin
            w_acc_nxt = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end
    end

    // Divide keeps {remainder, quotient}; remainder follows dividend sign
    assign w_fix_wide = !r_op[MDU_DIV_BIT] && (r_neg_a ^ r_neg_b);
    assign w_fix_hi   = r_op[MDU_DIV_BIT] && r_neg_a;
    assign w_fix_lo   = r_op[MDU_DIV_BIT] && (r_neg_a ^ r_neg_b);

    mdu_fixup #(.XLEN(XLEN)) u_fix_out (
        .i_val      (w_acc_nxt),
        .i_neg_wide (w_fix_wide),
        .i_neg_hi   (w_fix_hi),
        .i_neg_lo   (w_fix_lo),
        .o_val      (w_fix_val)
    );

    assign w_fix_res = r_op[MDU_DIV_BIT]
                     ? (r_op[1] ? w_fix_val[W2-1:XLEN] : w_fix_val[XLEN-1:0])
                     : ((r_op == OP_MUL) ? w_fix_val[XLEN-1:0] : w_fix_val[W2-1:XLEN]);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (in_valid && !kill) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_short ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == CNT_W'(XLEN - 1)) begin
                    w_last      = !kill;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (kill) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= OP_MUL;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_result <= '0;
        end else if (kill) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_op    <= w_op;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_mag[W2-1:XLEN] : w_mag[XLEN-1:0])};
            r_opb   <= w_is_div ? w_mag[XLEN-1:0] : w_mag[W2-1:XLEN];
            if (w_short) begin
                r_result <= w_short_res;
            end
        end else if (r_state == ST_CALC) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result <= w_fix_res;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_result;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: transaction-level reference model plus
// directed literal cases and randomized traffic with backpressure and kills.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, kill, out_valid, out_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b, out_result;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          chk_en  = 1'b0;
    bit          m_busy  = 1'b0;
    int          m_vedge = 0;
    logic [31:0] m_res   = '0;

    mdu_iter #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .kill       (kill),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          ia, ib;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: return a * b;
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from accept cycle N to first out_valid cycle
    function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: who owns the unit and when the result must appear
    always @(posedge clk) begin
        if (rst || kill) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy  = 1'b1;
                m_vedge = cyc + lat_of(in_op, in_a, in_b);
                m_res   = ref_op(in_op, in_a, in_b);
            end
        end else if (cyc >= m_vedge && out_ready) begin
            m_busy = 1'b0;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'(!m_busy));
            check("out_valid", 32'(out_valid), 32'(m_busy && cyc >= m_vedge));
            if (m_busy && cyc >= m_vedge) check("out_result", out_result, m_res);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int acc);
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        acc      = cyc;
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    task automatic wait_valid(input int acc, output int lat);
        int n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL valid_timeout: out_valid=%b required 1", out_valid);
        end
        lat = cyc - acc + 1;
    endtask

    task automatic run_dir(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int acc, lat;
        out_ready = 1'b1;
        issue(op, a, b, acc);
        wait_valid(acc, lat);
        check({name, "_res"}, out_result, exp_res);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, lat, n;
        rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
        in_op = 3'd0; in_a = '0; in_b = '0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_dir("mulhu_ff",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_dir("mul_ff",      OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT);
        run_dir("mulh_min",    OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_dir("mulhsu_ff",   OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_dir("div_m7_2",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_dir("rem_m7_2",    OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_dir("divu_100_7",  OP_DIVU,   32'd100,       32'd7,         32'd14,        33);
        run_dir("remu_100_7",  OP_REMU,   32'd100,       32'd7,         32'd2,         33);
        run_dir("divu_by0",    OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_dir("rem_by0",     OP_REM,    32'd5,         32'd0,         32'd5,         1);
        run_dir("div_ovf",     OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_dir("rem_ovf",     OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

        // Result held under backpressure
        out_ready = 1'b0;
        issue(OP_DIVU, 32'd100, 32'd7, acc);
        wait_valid(acc, lat);
        repeat (10) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", out_result, 32'd14);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("pop_valid", 32'(out_valid), 32'd0);
        check("pop_in_ready", 32'(in_ready), 32'd1);

        // Kill mid-calculation, then a fresh divide
        issue(OP_DIVU, 32'hDEAD_BEEF, 32'd3, acc);
        repeat (4) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_calc_valid", 32'(out_valid), 32'd0);
        check("kill_calc_ready", 32'(in_ready), 32'd1);
        run_dir("divu_after_kill", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

        // Kill beats a simultaneous request
        kill = 1'b1; in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd9; in_b = 32'd3;
        @(negedge clk);
        kill = 1'b0; in_valid = 1'b0;
        check("kill_req_ready", 32'(in_ready), 32'd1);
        repeat (40) @(negedge clk);
        check("kill_req_noresult", 32'(out_valid), 32'd0);

        // Kill in DONE drops the result even with out_ready high
        out_ready = 1'b0;
        issue(OP_REMU, 32'd100, 32'd7, acc);
        wait_valid(acc, lat);
        kill = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_done_valid", 32'(out_valid), 32'd0);
        check("kill_done_ready", 32'(in_ready), 32'd1);

        // Reset mid-calculation
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd3, acc);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_calc_ready", 32'(in_ready), 32'd1);
        check("rst_calc_valid", 32'(out_valid), 32'd0);
        check("rst_calc_result", out_result, 32'd0);

        // Randomized traffic with backpressure and occasional kills
        for (int t = 0; t < 200; t++) begin
            issue(3'($urandom), pick(), pick(), acc);
            n = 0;
            while (in_ready !== 1'b1 && n < 200) begin
                out_ready = ($urandom_range(0, 3) != 0);
                kill      = ($urandom_range(0, 99) == 0);
                @(negedge clk);
                n++;
            end
            kill = 1'b0;
        end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
